// File: rtl/pong_pkg.sv
// Shared Pong definitions: game-state encoding, the two-digit BCD type and
// the BCD conversion/increment helpers used by the score logic.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SERVE = 2'b01,
    ST_PLAY  = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Tens digit in [7:4], units digit in [3:0].
  typedef logic [7:0] bcd2_t;

  // Binary 0..99 to packed BCD; evaluated at elaboration for the win threshold.
  function automatic bcd2_t to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Saturating two-digit BCD increment; a BCD input always yields a BCD result.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    if (v == 8'h99)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD score register: synchronous clear wins over increment,
// and the count saturates at 99.
module bcd_counter2
  import pong_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_clr,
  input  logic  i_inc,
  output bcd2_t o_q
);

  bcd2_t r_q;

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_q <= '0;
    else if (i_clr)
      r_q <= '0;
    else if (i_inc)
      r_q <= bcd_inc(r_q);
  end

  assign o_q = r_q;

endmodule

// File: rtl/score_ctrl.sv
// Pong game sequencer: owns both BCD scores, times the serve delay,
// detects the winner and blinks the winner's digits on the display.
module score_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned SERVE_DELAY = 25_000_000,
  parameter int unsigned BLINK_BIT   = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       point_0,
  input  logic       point_1,
  output logic [7:0] score_0,
  output logic [7:0] score_1,
  output logic       blank_0,
  output logic       blank_1,
  output logic       serve,
  output logic       serve_dir,
  output logic [1:0] state,
  output logic       winner
);

  localparam int unsigned CNT_W   = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam int unsigned BLINK_W = BLINK_BIT + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_DELAY - 1);
  localparam bcd2_t WIN_BCD = to_bcd(WIN_SCORE);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [BLINK_W-1:0] r_blink, w_blink_next;
  logic               r_serve, w_serve_next;
  logic               r_serve_dir, w_serve_dir_next;
  logic               r_winner, w_winner_next;
  logic               r_blank_0, r_blank_1;
  logic               w_clr, w_inc_0, w_inc_1;
  bcd2_t              w_score_0, w_score_1;

  bcd_counter2 u_score_0 (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_inc (w_inc_0),
    .o_q   (w_score_0)
  );

  bcd_counter2 u_score_1 (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_inc (w_inc_1),
    .o_q   (w_score_1)
  );

  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_serve_dir_next = r_serve_dir;
    w_winner_next    = r_winner;
    w_clr            = 1'b0;
    w_inc_0          = 1'b0;
    w_inc_1          = 1'b0;

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          w_clr            = 1'b1;
          w_serve_dir_next = 1'b0;
          w_cnt_next       = CNT_LOAD;
          w_state_next     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (r_cnt == '0)
          w_state_next = ST_PLAY;
        else
          w_cnt_next = r_cnt - CNT_W'(1);
      end
      ST_PLAY: begin
        // Rally winner scores; the next serve heads toward the rally loser.
        case ({point_1, point_0})
          2'b01: begin
            w_inc_0 = 1'b1;
            if (bcd_inc(w_score_0) == WIN_BCD) begin
              w_winner_next = 1'b0;
              w_state_next  = ST_OVER;
            end else begin
              w_serve_dir_next = 1'b1;
              w_cnt_next       = CNT_LOAD;
              w_state_next     = ST_SERVE;
            end
          end
          2'b10: begin
            w_inc_1 = 1'b1;
            if (bcd_inc(w_score_1) == WIN_BCD) begin
              w_winner_next = 1'b1;
              w_state_next  = ST_OVER;
            end else begin
              w_serve_dir_next = 1'b0;
              w_cnt_next       = CNT_LOAD;
              w_state_next     = ST_SERVE;
            end
          end
          2'b11: begin
            w_cnt_next   = CNT_LOAD;
            w_state_next = ST_SERVE;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Serve fires on the edge where the countdown reaches zero while still in SERVE.
  assign w_serve_next = (w_state_next == ST_SERVE) && (w_cnt_next == '0);
  assign w_blink_next = (r_state == ST_OVER && w_state_next == ST_OVER)
                        ? r_blink + BLINK_W'(1) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_blink     <= '0;
      r_serve     <= 1'b0;
      r_serve_dir <= 1'b0;
      r_winner    <= 1'b0;
      r_blank_0   <= 1'b0;
      r_blank_1   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_blink     <= w_blink_next;
      r_serve     <= w_serve_next;
      r_serve_dir <= w_serve_dir_next;
      r_winner    <= w_winner_next;
      r_blank_0   <= (w_state_next == ST_OVER) && !w_winner_next && w_blink_next[BLINK_BIT];
      r_blank_1   <= (w_state_next == ST_OVER) &&  w_winner_next && w_blink_next[BLINK_BIT];
    end
  end

  assign score_0   = w_score_0;
  assign score_1   = w_score_1;
  assign blank_0   = r_blank_0;
  assign blank_1   = r_blank_1;
  assign serve     = r_serve;
  assign serve_dir = r_serve_dir;
  assign state     = r_state;
  assign winner    = r_winner;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl (WIN_SCORE=3, SERVE_DELAY=4, BLINK_BIT=2)
// plus a unit check of bcd_counter2.
module tb_score_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, point_0, point_1;
  logic [7:0] score_0, score_1;
  logic       blank_0, blank_1, serve, serve_dir, winner;
  logic [1:0] state;

  logic       bcd_clr, bcd_inc;
  logic [7:0] bcd_q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  score_ctrl #(.WIN_SCORE(3), .SERVE_DELAY(4), .BLINK_BIT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .point_0   (point_0),
    .point_1   (point_1),
    .score_0   (score_0),
    .score_1   (score_1),
    .blank_0   (blank_0),
    .blank_1   (blank_1),
    .serve     (serve),
    .serve_dir (serve_dir),
    .state     (state),
    .winner    (winner)
  );

  bcd_counter2 u_bcd (
    .clk   (clk),
    .reset (reset),
    .i_clr (bcd_clr),
    .i_inc (bcd_inc),
    .o_q   (bcd_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that entered SERVE: serve must appear
  // after the 3rd following edge and PLAY after the 4th.
  task automatic wait_serve(input string tag);
    for (int i = 1; i <= 3; i++) begin
      step();
      check({tag, "_serve"}, serve, (i == 3));
      check({tag, "_in_serve"}, state, 2'b01);
    end
    step();
    check({tag, "_play"}, state, 2'b10);
    check({tag, "_serve_low"}, serve, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; point_0 = 1'b0; point_1 = 1'b0;
    bcd_clr = 1'b0; bcd_inc = 1'b0;
    step(); step();
    check("rst_state", state, 2'b00);
    check("rst_scores", {score_1, score_0}, 16'h0000);
    check("rst_serve", serve, 1'b0);
    check("rst_dir", serve_dir, 1'b0);
    check("rst_winner", winner, 1'b0);
    check("rst_blanks", {blank_1, blank_0}, 2'b00);
    reset = 1'b0;
    step();

    // bcd_counter2 unit: 09+1 -> 10, 99+1 -> 99, clr -> 00
    bcd_inc = 1'b1;
    repeat (9) step();
    check("bcd_09", bcd_q, 8'h09);
    step();
    check("bcd_10", bcd_q, 8'h10);
    repeat (89) step();
    check("bcd_99", bcd_q, 8'h99);
    step();
    check("bcd_sat", bcd_q, 8'h99);
    bcd_inc = 1'b0; bcd_clr = 1'b1;
    step();
    bcd_clr = 1'b0;
    check("bcd_clr", bcd_q, 8'h00);

    // Points in IDLE are ignored
    point_0 = 1'b1; point_1 = 1'b0; step(); point_0 = 1'b0;
    check("idle_pt_scores", {score_1, score_0}, 16'h0000);
    check("idle_pt_state", state, 2'b00);

    // Start a game
    start = 1'b1; step(); start = 1'b0;
    check("start_state", state, 2'b01);
    check("start_scores", {score_1, score_0}, 16'h0000);
    wait_serve("s1");

    // Player 1 wins a rally
    point_1 = 1'b1; step(); point_1 = 1'b0;
    check("p1_scores", {score_1, score_0}, 16'h0100);
    check("p1_state", state, 2'b01);
    check("p1_dir", serve_dir, 1'b0);
    wait_serve("s2");

    // Player 0 wins a rally
    point_0 = 1'b1; step(); point_0 = 1'b0;
    check("p0a_scores", {score_1, score_0}, 16'h0101);
    check("p0a_dir", serve_dir, 1'b1);
    wait_serve("s3");

    // Let: both points together
    point_0 = 1'b1; point_1 = 1'b1; step(); point_0 = 1'b0; point_1 = 1'b0;
    check("let_scores", {score_1, score_0}, 16'h0101);
    check("let_state", state, 2'b01);
    check("let_dir", serve_dir, 1'b1);

    // Points during SERVE, including one on the serve cycle
    point_0 = 1'b1; step(); point_0 = 1'b0;
    check("serve_pt_scores", {score_1, score_0}, 16'h0101);
    step(); step();
    check("serve_cycle", serve, 1'b1);
    point_1 = 1'b1; start = 1'b1; step(); point_1 = 1'b0; start = 1'b0;
    check("serve_edge_pt_scores", {score_1, score_0}, 16'h0101);
    check("serve_edge_pt_state", state, 2'b10);

    // Player 0 wins two more -> 03, game over
    point_0 = 1'b1; step(); point_0 = 1'b0;
    check("p0b_scores", {score_1, score_0}, 16'h0102);
    check("p0b_state", state, 2'b01);
    wait_serve("s4");
    point_0 = 1'b1; step(); point_0 = 1'b0;
    check("win_score", score_0, 8'h03);
    check("win_state", state, 2'b11);
    check("win_winner", winner, 1'b0);
    check("win_blanks", {blank_1, blank_0}, 2'b00);

    // Blink: blank_0 follows blink counter bit 2; points ignored in OVER
    for (int k = 1; k <= 10; k++) begin
      point_0 = (k == 5);
      point_1 = (k == 7);
      step();
      check("blink_b0", blank_0, (k / 4) % 2);
      check("blink_b1", blank_1, 1'b0);
      check("over_scores", {score_1, score_0}, 16'h0103);
    end
    point_0 = 1'b0; point_1 = 1'b0;

    // Start together with a point in OVER: start wins
    start = 1'b1; point_0 = 1'b1; step(); start = 1'b0; point_0 = 1'b0;
    check("restart_state", state, 2'b01);
    check("restart_scores", {score_1, score_0}, 16'h0000);
    check("restart_blanks", {blank_1, blank_0}, 2'b00);
    check("restart_dir", serve_dir, 1'b0);
    wait_serve("s5");

    // Reset in the middle of the serve delay
    point_1 = 1'b1; step(); point_1 = 1'b0;
    check("pre_rst_score", score_1, 8'h01);
    step();
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", state, 2'b00);
    check("async_rst_scores", {score_1, score_0}, 16'h0000);
    check("async_rst_serve", serve, 1'b0);
    step();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      point_0 = (k == 3);
      point_1 = (k == 6);
      step();
      check("post_rst_serve", serve, 1'b0);
      check("post_rst_state", state, 2'b00);
    end
    point_0 = 1'b0; point_1 = 1'b0;
    check("post_rst_scores", {score_1, score_0}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
